// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared constants, fetch FSM encoding and alignment helper
package instr_fetch_unit_pkg;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch-stage bundle of imem bus, decode hand-off and redirect signals
interface instr_fetch_unit_if;
    logic        Stall;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ready;
    logic [31:0] IMem_RData;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Instr_Valid;
    logic        Fetch_Misaligned;
    modport master (
        input  Stall, PCSrc, PCTarget, IMem_Ready, IMem_RData,
        output IMem_Req, IMem_Addr, Instr, PC, PCPlus4, Instr_Valid, Fetch_Misaligned
    );
    modport slave (
        output Stall, PCSrc, PCTarget, IMem_Ready, IMem_RData,
        input  IMem_Req, IMem_Addr, Instr, PC, PCPlus4, Instr_Valid, Fetch_Misaligned
    );
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// instr_fetch_unit_pc_reg: fetch address register with redirect load and +4 advance
module instr_fetch_unit_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] target,
    input  logic        inc,
    output logic [31:0] pc
);
    logic [31:0] pc_q, pc_d;
    always_comb begin
        pc_d = load ? word_align(target) : inc ? pc_q + 32'd4 : pc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end
    assign pc = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage presenting one captured instruction word and its PC to decode
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    instr_fetch_unit_if.master  bus
);
    fetch_state_e state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic         mis_q, mis_d;
    logic [31:0]  fetch_pc;
    logic         req, capture, consume;
    instr_fetch_unit_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (bus.PCSrc),
        .target (bus.PCTarget),
        .inc    (capture),
        .pc     (fetch_pc)
    );
    // A redirect overrides everything: the same-cycle response and any stall are dropped.
    always_comb begin
        req     = (state_q == FETCH) && !(valid_q && bus.Stall) && !bus.PCSrc;
        capture = req && bus.IMem_Ready;
        consume = valid_q && !bus.Stall;
        state_d = bus.PCSrc ? FLUSH : FETCH;
        valid_d = !bus.PCSrc && (capture || (valid_q && bus.Stall));
        instr_d = bus.PCSrc ? NOP_INSTR : capture ? bus.IMem_RData : consume ? NOP_INSTR : instr_q;
        pc_d    = capture ? fetch_pc : pc_q;
        mis_d   = mis_q || (bus.PCSrc && (bus.PCTarget[1:0] != 2'b00));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end
    assign bus.IMem_Req         = req;
    assign bus.IMem_Addr        = fetch_pc;
    assign bus.Instr            = instr_q;
    assign bus.PC               = pc_q;
    assign bus.PCPlus4          = pc_q + 32'd4;
    assign bus.Instr_Valid      = valid_q;
    assign bus.Fetch_Misaligned = mis_q;
endmodule
